// File: rtl/ahf_mbox_pkg.sv
// ----------------------------------------------------------------------------
// ahf_mbox_pkg
// Shared constants and state encodings for the inter-core mailbox responder.
//   MBOX_DW    : core word width
//   MBOX_DEPTH : mailbox FIFO entries (power of two, >= 2)
//   MBOX_AW    : log2(MBOX_DEPTH), FIFO pointer width
// ----------------------------------------------------------------------------
package ahf_mbox_pkg;

  localparam int MBOX_DW    = 14;
  localparam int MBOX_DEPTH = 8;
  localparam int MBOX_AW    = 3;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/ahf_mbox_resp_if.sv
// ----------------------------------------------------------------------------
// ahf_mbox_resp_if
// Bundle of the writer-core and reader-core handshake lines plus status.
//   Write_in/Data_wr -> Done_wr   : writer side request, data, busy/ack
//   Read_in          -> Data_rd/Done_rd : reader side request, data, busy/ack
//   Count/Full/Empty              : FIFO occupancy status
// Modports: slave = responder (mailbox), master = the cores driving it.
// ----------------------------------------------------------------------------
interface ahf_mbox_resp_if #(
  parameter int DW = ahf_mbox_pkg::MBOX_DW,
  parameter int AW = ahf_mbox_pkg::MBOX_AW
);

  logic          Write_in;
  logic [DW-1:0] Data_wr;
  logic          Done_wr;
  logic          Read_in;
  logic [DW-1:0] Data_rd;
  logic          Done_rd;
  logic [AW:0]   Count;
  logic          Full;
  logic          Empty;

  modport slave (
    input  Write_in, Data_wr, Read_in,
    output Done_wr, Data_rd, Done_rd, Count, Full, Empty
  );

  modport master (
    output Write_in, Data_wr, Read_in,
    input  Done_wr, Data_rd, Done_rd, Count, Full, Empty
  );

endinterface

// File: rtl/ahf_mbox_fifo.sv
// ----------------------------------------------------------------------------
// ahf_mbox_fifo
// Storage for the mailbox: circular buffer with separate occupancy counter so
// full and empty are unambiguous even though the pointers wrap.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data at the write pointer (caller guarantees !o_full)
//   i_pop      : advance the read pointer (caller guarantees !o_empty)
//   o_head     : entry at the read pointer
//   o_count    : registered occupancy 0..DEPTH; o_full/o_empty decoded from it
// ----------------------------------------------------------------------------
module ahf_mbox_fifo #(
  parameter int DW    = ahf_mbox_pkg::MBOX_DW,
  parameter int DEPTH = ahf_mbox_pkg::MBOX_DEPTH,
  parameter int AW    = ahf_mbox_pkg::MBOX_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] L_DEPTH = DEPTH[AW:0];

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage is not reset; its contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == L_DEPTH);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/ahf_mbox_resp.sv
// ----------------------------------------------------------------------------
// ahf_mbox_resp
// Responder end of the core I/O-port Read/Write/Done handshake. A writer core
// pushes one word per Write_in request, a reader core pops one word per
// Read_in request; Done_* low is the acknowledge, held until the request drops.
//   Clk_pin   : system clock
//   Reset_pin : asynchronous active-low reset
//   bus       : slave modport of ahf_mbox_resp_if (handshakes + status)
// ----------------------------------------------------------------------------
module ahf_mbox_resp
  import ahf_mbox_pkg::*;
#(
  parameter int DW    = MBOX_DW,
  parameter int DEPTH = MBOX_DEPTH,
  parameter int AW    = MBOX_AW
) (
  input  logic           Clk_pin,
  input  logic           Reset_pin,
  ahf_mbox_resp_if.slave bus
);

  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_head;
  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;

  wr_state_t     r_wstate;
  rd_state_t     r_rstate;
  logic          r_done_wr;
  logic          r_done_rd;
  logic [DW-1:0] r_data_rd;

  // Full/Empty come from the registered count, so a same-edge pop never
  // admits a push into a full FIFO and a same-edge push never feeds a pop
  // from an empty one.
  assign w_push = (r_wstate == W_IDLE) && bus.Write_in && !w_full;
  assign w_pop  = (r_rstate == R_IDLE) && bus.Read_in  && !w_empty;

  ahf_mbox_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (Clk_pin),
    .rst_n   (Reset_pin),
    .i_push  (w_push),
    .i_data  (bus.Data_wr),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Writer: one push per request, ack held until Write_in drops.
  always_ff @(posedge Clk_pin or negedge Reset_pin) begin
    if (!Reset_pin) begin
      r_wstate  <= W_IDLE;
      r_done_wr <= 1'b1;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_push) begin
            r_wstate  <= W_ACK;
            r_done_wr <= 1'b0;
          end
        end
        W_ACK: begin
          if (!bus.Write_in) begin
            r_wstate  <= W_IDLE;
            r_done_wr <= 1'b1;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_done_wr <= 1'b1;
        end
      endcase
    end
  end

  // Reader: one pop per request; Data_rd is held after the handshake ends.
  always_ff @(posedge Clk_pin or negedge Reset_pin) begin
    if (!Reset_pin) begin
      r_rstate  <= R_IDLE;
      r_done_rd <= 1'b1;
      r_data_rd <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_pop) begin
            r_rstate  <= R_ACK;
            r_done_rd <= 1'b0;
            r_data_rd <= w_head;
          end
        end
        R_ACK: begin
          if (!bus.Read_in) begin
            r_rstate  <= R_IDLE;
            r_done_rd <= 1'b1;
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_done_rd <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Done_wr = r_done_wr;
  assign bus.Done_rd = r_done_rd;
  assign bus.Data_rd = r_data_rd;
  assign bus.Count   = w_count;
  assign bus.Full    = w_full;
  assign bus.Empty   = w_empty;

endmodule

// File: tb/tb_ahf_mbox_resp.sv
// ----------------------------------------------------------------------------
// tb_ahf_mbox_resp
// Directed bench for ahf_mbox_resp. Read requests push their expected word
// into a scoreboard queue; a monitor pops and compares whenever Done_rd falls.
// ----------------------------------------------------------------------------
module tb_ahf_mbox_resp;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahf_mbox_resp_if mb ();

  ahf_mbox_resp dut (
    .Clk_pin   (clk),
    .Reset_pin (rst_n),
    .bus       (mb.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [13:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each falling edge of Done_rd is one delivered word.
  logic        prev_done_rd = 1'b1;
  logic [13:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && prev_done_rd && (mb.Done_rd == 1'b0)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop: unexpected word got %0h expected none", mb.Data_rd);
      end else begin
        mon_exp = sb.pop_front();
        if (mb.Data_rd !== mon_exp) begin
          bad++;
          $display("FAIL pop: got %0h expected %0h", mb.Data_rd, mon_exp);
        end else begin
          $display("read  %04h count=%0d", mb.Data_rd, mb.Count);
        end
      end
    end
    prev_done_rd = mb.Done_rd;
  end

  // Bounded wait, sampled on negedges, for a Done line to reach a level.
  task automatic wait_done(input string name, input bit is_wr, input logic lvl);
    int n = 0;
    while (((is_wr ? mb.Done_wr : mb.Done_rd) !== lvl) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL %s: got timeout expected level %0b", name, lvl);
    end
  endtask

  task automatic do_write(input logic [13:0] d);
    @(negedge clk);
    mb.Write_in = 1'b1;
    mb.Data_wr  = d;
    wait_done("wr_ack", 1'b1, 1'b0);
    mb.Write_in = 1'b0;
    mb.Data_wr  = 'x;
    wait_done("wr_rel", 1'b1, 1'b1);
    $display("write %04h count=%0d", d, mb.Count);
  endtask

  task automatic do_read(input logic [13:0] e);
    sb.push_back(e);
    @(negedge clk);
    mb.Read_in = 1'b1;
    wait_done("rd_ack", 1'b0, 1'b0);
    mb.Read_in = 1'b0;
    wait_done("rd_rel", 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mb.Write_in = 1'b0;
    mb.Read_in  = 1'b0;
    mb.Data_wr  = '0;

    // ---- reset state and asynchronous reset ----
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_done_wr", mb.Done_wr, 1);
    check("rst_done_rd", mb.Done_rd, 1);
    check("rst_count",   mb.Count,   0);
    check("rst_empty",   mb.Empty,   1);
    check("rst_full",    mb.Full,    0);
    check("rst_data_rd", mb.Data_rd, 0);
    @(negedge clk);
    mb.Write_in = 1'b1;
    mb.Data_wr  = 14'h0123;
    @(negedge clk);
    check("pre_async_done_wr", mb.Done_wr, 0);
    check("pre_async_count",   mb.Count,   1);
    #2 rst_n = 1'b0;
    #1;
    check("async_done_wr", mb.Done_wr, 1);
    check("async_done_rd", mb.Done_rd, 1);
    check("async_count",   mb.Count,   0);
    check("async_empty",   mb.Empty,   1);
    mb.Write_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single transfer, request held 5 cycles ----
    @(negedge clk);
    mb.Write_in = 1'b1;
    mb.Data_wr  = 14'h01A5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done_wr", mb.Done_wr, 0);
      check("hold_count",   mb.Count,   1);
    end
    mb.Write_in = 1'b0;
    @(negedge clk);
    check("drop_done_wr", mb.Done_wr, 1);
    check("drop_count",   mb.Count,   1);
    do_read(14'h01A5);
    check("single_count",   mb.Count,   0);
    check("single_empty",   mb.Empty,   1);
    check("single_data_rd", mb.Data_rd, 14'h01A5);

    // ---- fill to full, stalled 9th write ----
    for (int i = 1; i <= 8; i++) do_write(14'(i));
    check("fill_full",  mb.Full,  1);
    check("fill_count", mb.Count, 8);
    @(negedge clk);
    mb.Write_in = 1'b1;
    mb.Data_wr  = 14'h0009;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_stall_done_wr", mb.Done_wr, 1);
    end
    do_read(14'h0001);
    check("retry_done_wr", mb.Done_wr, 0);
    check("retry_count",   mb.Count,   8);
    mb.Write_in = 1'b0;
    wait_done("retry_rel", 1'b1, 1'b1);
    for (int i = 2; i <= 9; i++) do_read(14'(i));
    check("drain_empty", mb.Empty, 1);

    // ---- empty stall, then write releases the waiting read ----
    sb.push_back(14'h3FFE);
    @(negedge clk);
    mb.Read_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_stall_done_rd", mb.Done_rd, 1);
    end
    mb.Write_in = 1'b1;
    mb.Data_wr  = 14'h3FFE;
    @(negedge clk);
    check("edgeA_done_wr", mb.Done_wr, 0);
    check("edgeA_done_rd", mb.Done_rd, 1);
    mb.Write_in = 1'b0;
    @(negedge clk);
    check("edgeB_done_rd", mb.Done_rd, 0);
    check("edgeB_data_rd", mb.Data_rd, 14'h3FFE);
    mb.Read_in = 1'b0;
    @(negedge clk);
    check("after_done_rd", mb.Done_rd, 1);
    check("after_done_wr", mb.Done_wr, 1);
    check("after_count",   mb.Count,   0);

    // ---- 20 write/read pairs: pointers wrap more than twice ----
    for (int i = 0; i < 20; i++) begin
      logic [13:0] d;
      d = 14'(14'h2000 + i * 37);
      do_write(d);
      do_read(d);
    end

    // ---- simultaneous push and pop with Count = 3 ----
    do_write(14'h0111);
    do_write(14'h0222);
    do_write(14'h0333);
    check("sim_pre_count", mb.Count, 3);
    sb.push_back(14'h0111);
    @(negedge clk);
    mb.Write_in = 1'b1;
    mb.Data_wr  = 14'h0444;
    mb.Read_in  = 1'b1;
    @(negedge clk);
    check("sim_count",   mb.Count,   3);
    check("sim_done_wr", mb.Done_wr, 0);
    check("sim_done_rd", mb.Done_rd, 0);
    mb.Write_in = 1'b0;
    mb.Read_in  = 1'b0;
    @(negedge clk);
    check("sim_rel_count", mb.Count, 3);
    do_read(14'h0222);
    do_read(14'h0333);
    do_read(14'h0444);

    // ---- reset while reader is in R_ACK with Count = 5 ----
    for (int i = 0; i < 6; i++) do_write(14'(14'h0500 + i));
    sb.push_back(14'h0500);
    @(negedge clk);
    mb.Read_in = 1'b1;
    wait_done("mid_rd_ack", 1'b0, 1'b0);
    check("mid_count", mb.Count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count",   mb.Count,   0);
    check("mid_rst_done_rd", mb.Done_rd, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_done_rd", mb.Done_rd, 1);
    end
    sb.push_back(14'h1234);
    do_write(14'h1234);
    check("post_rst_pop_done_rd", mb.Done_rd, 0);
    check("post_rst_pop_data",    mb.Data_rd, 14'h1234);
    mb.Read_in = 1'b0;
    wait_done("post_rst_rd_rel", 1'b0, 1'b1);
    check("final_empty", mb.Empty, 1);
    check("sb_drained",  sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
